// File: rtl/knn_image_binarizer.sv
// knn_image_binarizer
// Front end for the kNN classifier. It collects a 16x16 8-bit grayscale frame
// arriving as a raster pixel stream, thresholds every pixel to a single bit and
// packs the result into test_image, with pixel k at bit k. When the frame is
// complete it raises valid. valid and test_image stay stable for HOLD_CYCLES
// cycles, which is long enough for the classifier's full row scan. valid then
// stays low for GAP_CYCLES cycles so the classifier returns to IDLE before the
// block accepts the next frame.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous reset, active low
//   pix_valid   pixel stream valid
//   pix_ready   block can accept a pixel (transfer = pix_valid & pix_ready)
//   pix_data    8-bit grayscale pixel, raster order
//   pix_last    marks pixel NUM_PIX-1 of a frame
//   threshold   binarization threshold, sampled on the first pixel of a frame
//   test_image  packed binary image for the classifier
//   valid       test_image valid / classifier start
//   busy        high while holding or in the gap after a hold
//   frame_err   one-cycle pulse on an early or missing pix_last
module knn_image_binarizer #(
  parameter int NUM_PIX     = 256,
  parameter int HOLD_CYCLES = 608,
  parameter int GAP_CYCLES  = 2,
  parameter bit INVERT      = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [7:0]         pix_data,
  input  logic               pix_last,
  input  logic [7:0]         threshold,
  output logic [NUM_PIX-1:0] test_image,
  output logic               valid,
  output logic               busy,
  output logic               frame_err
);

  localparam int IDX_W = $clog2(NUM_PIX);
  localparam int CNT_W = $clog2((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PIX - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    COLLECT,
    HOLD,
    GAP
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   pix_idx;
  logic [CNT_W-1:0]   counter;
  logic [7:0]         thr_q;
  logic [NUM_PIX-1:0] shadow;

  logic [7:0]         eff_thr;
  logic               pix_bit;
  logic               is_last;
  logic [NUM_PIX-1:0] next_shadow;

  // The threshold is captured on the first pixel of a frame, and that
  // first pixel has to be compared against the freshly sampled value rather
  // than the stale register. next_shadow is the shadow image with the current
  // pixel's bit merged in, so a completing frame can publish all its bits at once.
  always_comb begin
    eff_thr     = (pix_idx == '0) ? threshold : thr_q;
    pix_bit     = INVERT ? (pix_data <= eff_thr) : (pix_data > eff_thr);
    is_last     = (pix_idx == LAST_IDX);
    next_shadow = shadow;
    next_shadow[pix_idx] = pix_bit;
  end

  // Main control FSM. In COLLECT it accepts pixels and checks framing. In HOLD
  // it presents the image with valid for HOLD_CYCLES cycles. In GAP valid is
  // low and the input stays blocked. pix_ready is a registered output, so it
  // comes up one edge after reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      pix_idx    <= '0;
      counter    <= '0;
      thr_q      <= '0;
      shadow     <= '0;
      test_image <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      pix_ready  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        COLLECT: begin
          if (!pix_ready) begin
            pix_ready <= 1'b1;
          end else if (pix_valid) begin
            if (pix_idx == '0) begin
              thr_q <= threshold;
            end
            if (is_last && pix_last) begin
              test_image <= next_shadow;
              valid      <= 1'b1;
              busy       <= 1'b1;
              pix_ready  <= 1'b0;
              counter    <= HOLD_LOAD;
              pix_idx    <= '0;
              state      <= HOLD;
            end else if (is_last || pix_last) begin
              // The frame is discarded. The published image and valid
              // are left untouched.
              frame_err <= 1'b1;
              pix_idx   <= '0;
            end else begin
              shadow  <= next_shadow;
              pix_idx <= pix_idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (counter == '0) begin
            valid   <= 1'b0;
            counter <= GAP_LOAD;
            state   <= GAP;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        GAP: begin
          if (counter == '0) begin
            pix_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= COLLECT;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_image_binarizer.sv
// tb_knn_image_binarizer
// Directed bench for knn_image_binarizer. It runs two instances that share
// every input: one with INVERT=0 and one with INVERT=1. Pixels are driven on
// the falling edge and outputs are sampled on the falling edge. Expected
// images are hand-derived constants.
module tb_knn_image_binarizer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pix_valid = 1'b0;
  logic         pix_last = 1'b0;
  logic [7:0]   pix_data = 8'h00;
  logic [7:0]   threshold = 8'h00;

  logic         pix_ready, valid, busy, frame_err;
  logic [255:0] test_image;
  logic         pix_ready_inv, valid_inv, busy_inv, frame_err_inv;
  logic [255:0] test_image_inv;

  int checks = 0;
  int fails = 0;

  localparam logic [255:0] RAMP_EXP = {{128{1'b1}}, {128{1'b0}}};
  localparam logic [255:0] ONES     = {256{1'b1}};
  localparam logic [255:0] ZEROS    = '0;

  knn_image_binarizer #(.INVERT(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .threshold  (threshold),
    .test_image (test_image),
    .valid      (valid),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  knn_image_binarizer #(.INVERT(1'b1)) dut_inv (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready_inv),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .threshold  (threshold),
    .test_image (test_image_inv),
    .valid      (valid_inv),
    .busy       (busy_inv),
    .frame_err  (frame_err_inv)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs from
  // the expected value.
  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pixVal(input int mode, input int k);
    case (mode)
      0:       return 8'(k);
      1:       return 8'hFF;
      default: return 8'h80;
    endcase
  endfunction

  // Wait (bounded) for pix_ready, then present one pixel so it transfers on
  // the next rising edge. Return on the falling edge after that transfer.
  task automatic applyStimulus(input logic [7:0] d, input logic l, input logic [7:0] t);
    int w = 0;
    while (pix_ready !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      checkOutput("ready_wait", 256'(pix_ready), 256'(1));
      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $fatal(1, "[TB] pix_ready never rose");
    end
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = l;
    threshold = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sendFrame(input int mode, input int n, input int last_at,
                           input logic [7:0] thr_a, input logic [7:0] thr_b,
                           input int switch_at, input bit keep_valid);
    for (int k = 0; k < n; k++) begin
      applyStimulus(pixVal(mode, k), (k == last_at), (k < switch_at) ? thr_a : thr_b);
    end
    if (!keep_valid) begin
      pix_valid = 1'b0;
      pix_last  = 1'b0;
    end
  endtask

  task automatic waitReady();
    int w = 0;
    while (pix_ready !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    checkOutput("wait_ready", 256'(pix_ready), 256'(1));
  endtask

  initial begin
    int cnt;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_image", test_image, ZEROS);
    checkOutput("rst_valid", 256'(valid), 256'(0));
    checkOutput("rst_busy", 256'(busy), 256'(0));
    checkOutput("rst_err", 256'(frame_err), 256'(0));
    checkOutput("rst_ready", 256'(pix_ready), 256'(0));
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", 256'(pix_ready), 256'(0));
    @(negedge clk);
    checkOutput("ready_after_edge", 256'(pix_ready), 256'(1));

    // Ramp frame, thr=127
    sendFrame(0, 256, 255, 8'd127, 8'd127, 256, 1'b0);
    checkOutput("ramp_valid_latency", 256'(valid), 256'(1));
    checkOutput("ramp_image", test_image, RAMP_EXP);
    checkOutput("ramp_image_inv", test_image_inv, ~RAMP_EXP);
    checkOutput("hold_busy", 256'(busy), 256'(1));
    checkOutput("hold_ready", 256'(pix_ready), 256'(0));
    cnt = 0;
    while (valid === 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("valid_width", 256'(cnt), 256'(608));
    checkOutput("image_held", test_image, RAMP_EXP);
    checkOutput("gap_busy", 256'(busy), 256'(1));
    cnt = 0;
    while (pix_ready !== 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("gap_len", 256'(cnt), 256'(2));
    checkOutput("idle_busy", 256'(busy), 256'(0));

    // All 0xFF, thr=0xFF
    sendFrame(1, 256, 255, 8'hFF, 8'hFF, 256, 1'b0);
    checkOutput("ff_image", test_image, ZEROS);
    checkOutput("ff_image_inv", test_image_inv, ONES);
    waitReady();

    // Early pix_last on pixel 100
    sendFrame(0, 101, 100, 8'd127, 8'd127, 256, 1'b0);
    checkOutput("early_err", 256'(frame_err), 256'(1));
    checkOutput("early_valid", 256'(valid), 256'(0));
    checkOutput("early_image", test_image, ZEROS);
    @(negedge clk);
    checkOutput("early_err_pulse", 256'(frame_err), 256'(0));

    // Missing pix_last on pixel 255
    sendFrame(2, 256, 1000, 8'h10, 8'h10, 256, 1'b0);
    checkOutput("late_err", 256'(frame_err), 256'(1));
    checkOutput("late_valid", 256'(valid), 256'(0));
    checkOutput("late_image", test_image, ZEROS);
    @(negedge clk);
    checkOutput("late_err_pulse", 256'(frame_err), 256'(0));

    // Recovery frame after errors
    sendFrame(0, 256, 255, 8'd127, 8'd127, 256, 1'b0);
    checkOutput("recover_image", test_image, RAMP_EXP);
    waitReady();

    // Back-to-back frames with pix_valid held high
    sendFrame(2, 256, 255, 8'hF0, 8'hF0, 256, 1'b1);
    checkOutput("b2b1_image", test_image, ZEROS);
    cnt = 0;
    while (pix_ready !== 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("b2b_ready_low", 256'(cnt), 256'(610));
    checkOutput("b2b_valid_low", 256'(valid), 256'(0));
    sendFrame(0, 256, 255, 8'd127, 8'd127, 256, 1'b0);
    checkOutput("b2b2_image", test_image, RAMP_EXP);
    waitReady();

    // Threshold change mid-frame (0x10 -> 0xF0 at pixel 50), all 0x80
    sendFrame(2, 256, 255, 8'h10, 8'hF0, 50, 1'b0);
    checkOutput("thr_image", test_image, ONES);
    checkOutput("thr_image_inv", test_image_inv, ZEROS);

    // Reset pulse during HOLD
    repeat (5) @(negedge clk);
    checkOutput("pre_rst_valid", 256'(valid), 256'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 256'(valid), 256'(0));
    checkOutput("mid_rst_image", test_image, ZEROS);
    checkOutput("mid_rst_busy", 256'(busy), 256'(0));
    checkOutput("mid_rst_ready", 256'(pix_ready), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_ready_before_edge", 256'(pix_ready), 256'(0));
    @(negedge clk);
    checkOutput("rel_ready_after_edge", 256'(pix_ready), 256'(1));
    sendFrame(0, 256, 255, 8'd127, 8'd127, 256, 1'b0);
    checkOutput("post_rst_valid", 256'(valid), 256'(1));
    checkOutput("post_rst_image", test_image, RAMP_EXP);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
